// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP multiplier rounding path.
// Contents: operand/result widths, the rounding-mode enum and the packed
// per-lane request bundle that is handed to the rounding unit.
package fp_mult_pkg;

   localparam int unsigned MANT_W = 24;
   localparam int unsigned EXP_W  = 10;
   localparam int unsigned RES_W  = 25;

   typedef enum logic [2:0] {
      RND_NE = 3'b000,  // nearest, ties to even
      RND_RZ = 3'b001,  // toward zero
      RND_RP = 3'b010,  // toward +inf
      RND_RM = 3'b011,  // toward -inf
      RND_NU = 3'b100,  // nearest, ties up
      RND_RA = 3'b101   // away from zero
   } round_set;

   typedef struct packed {
      logic [MANT_W-1:0] mantissa;
      logic              guard;
      logic              sticky;
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [2:0]        round;
   } lane_req_t;

endpackage

// File: rtl/round_share_arb_if.sv
// Bundle of lane request handshakes and the result handshake of round_share_arb.
// master: the side that drives lane requests and consumes results.
// slave : the arbiter itself.
interface round_share_arb_if;
   import fp_mult_pkg::*;

   logic                in0_valid, in0_ready;
   logic [MANT_W-1:0]   in0_mantissa;
   logic                in0_guard, in0_sticky, in0_sign;
   logic [EXP_W-1:0]    in0_exp;
   logic [2:0]          in0_round;

   logic                in1_valid, in1_ready;
   logic [MANT_W-1:0]   in1_mantissa;
   logic                in1_guard, in1_sticky, in1_sign;
   logic [EXP_W-1:0]    in1_exp;
   logic [2:0]          in1_round;

   logic                out_valid, out_ready, out_lane;
   logic [RES_W-1:0]    out_result;
   logic [EXP_W-1:0]    out_exp;
   logic                out_inexact, out_sign;
   logic [15:0]         stall_cnt;

   modport master (
      output in0_valid, in0_mantissa, in0_guard, in0_sticky, in0_sign, in0_exp, in0_round,
      output in1_valid, in1_mantissa, in1_guard, in1_sticky, in1_sign, in1_exp, in1_round,
      input  in0_ready, in1_ready,
      output out_ready,
      input  out_valid, out_lane, out_result, out_exp, out_inexact, out_sign, stall_cnt
   );

   modport slave (
      input  in0_valid, in0_mantissa, in0_guard, in0_sticky, in0_sign, in0_exp, in0_round,
      input  in1_valid, in1_mantissa, in1_guard, in1_sticky, in1_sign, in1_exp, in1_round,
      output in0_ready, in1_ready,
      input  out_ready,
      output out_valid, out_lane, out_result, out_exp, out_inexact, out_sign, stall_cnt
   );

endinterface

// File: rtl/round_mult.sv
// Combinational IEEE-754 single-precision mantissa rounder.
// req     : mantissa, guard, sticky, sign, exponent and rounding mode
// result  : rounded mantissa; on carry-out it is {1, sum[24:1]}
// exp     : exponent, +1 on carry-out (modulo 2^EXP_W)
// inexact : guard | sticky
module round_mult
   import fp_mult_pkg::*;
(
   input  lane_req_t          req,
   output logic [RES_W-1:0]   result,
   output logic [EXP_W-1:0]   exp,
   output logic               inexact
);

   logic             inc;
   logic             lost;
   logic [RES_W-1:0] sum;

   assign lost = req.guard | req.sticky;

   always_comb begin
      inc = 1'b0;
      case (req.round)
         RND_RZ:  inc = 1'b0;
         RND_RP:  inc = !req.sign && lost;
         RND_RM:  inc = req.sign && lost;
         RND_NU:  inc = req.guard;
         RND_RA:  inc = lost;
         // 000 and the unused codes 110/111 all round to nearest-even
         default: inc = req.guard && (req.sticky || req.mantissa[0]);
      endcase
   end

   assign sum     = {1'b0, req.mantissa} + {{(RES_W-1){1'b0}}, inc};
   assign result  = sum[RES_W-1] ? {1'b1, sum[RES_W-1:1]} : sum;
   assign exp     = req.exp + {{(EXP_W-1){1'b0}}, sum[RES_W-1]};
   assign inexact = lost;

endmodule

// File: rtl/round_share_arb.sv
// Two-lane arbiter in front of one shared rounding unit.
// clk, rst_n : clock and asynchronous active-low reset
// bus        : lane request handshakes, registered result with lane tag and
//              a saturating count of cycles in which some lane was stalled
// PRIO_FIXED : 0 = round-robin between lanes, 1 = lane 0 always wins
module round_share_arb
   import fp_mult_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
)
(
   input  logic             clk,
   input  logic             rst_n,
   round_share_arb_if.slave bus
);

   lane_req_t        req0, req1, req_sel;
   logic             grant, last_grant;
   logic             out_free, ready0, ready1, accept, stall;
   logic [RES_W-1:0] rnd_result;
   logic [EXP_W-1:0] rnd_exp;
   logic             rnd_inexact;

   logic             out_valid_q, out_lane_q, out_inexact_q, out_sign_q;
   logic [RES_W-1:0] out_result_q;
   logic [EXP_W-1:0] out_exp_q;
   logic [15:0]      stall_q;

   assign req0 = '{mantissa: bus.in0_mantissa, guard: bus.in0_guard, sticky: bus.in0_sticky,
                   sign: bus.in0_sign, exp: bus.in0_exp, round: bus.in0_round};
   assign req1 = '{mantissa: bus.in1_mantissa, guard: bus.in1_guard, sticky: bus.in1_sticky,
                   sign: bus.in1_sign, exp: bus.in1_exp, round: bus.in1_round};

   always_comb begin
      grant = 1'b0;
      if (bus.in0_valid && bus.in1_valid)
         grant = PRIO_FIXED ? 1'b0 : !last_grant;
      else if (bus.in1_valid)
         grant = 1'b1;
   end

   // rst_n gates ready so no lane sees a handshake while reset is held
   assign out_free = !out_valid_q || bus.out_ready;
   assign ready0   = rst_n && out_free && !grant && bus.in0_valid;
   assign ready1   = rst_n && out_free &&  grant && bus.in1_valid;
   assign accept   = ready0 || ready1;
   assign stall    = (bus.in0_valid && !ready0) || (bus.in1_valid && !ready1);
   assign req_sel  = grant ? req1 : req0;

   round_mult u_round (
      .req     (req_sel),
      .result  (rnd_result),
      .exp     (rnd_exp),
      .inexact (rnd_inexact)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_lane_q    <= 1'b0;
         out_result_q  <= '0;
         out_exp_q     <= '0;
         out_inexact_q <= 1'b0;
         out_sign_q    <= 1'b0;
         last_grant    <= 1'b1;
         stall_q       <= '0;
      end else begin
         if (accept) begin
            out_valid_q   <= 1'b1;
            out_lane_q    <= grant;
            out_result_q  <= rnd_result;
            out_exp_q     <= rnd_exp;
            out_inexact_q <= rnd_inexact;
            out_sign_q    <= req_sel.sign;
            last_grant    <= grant;
         end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
         end
         if (stall && (stall_q != '1))
            stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.in0_ready   = ready0;
   assign bus.in1_ready   = ready1;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_lane    = out_lane_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_exp     = out_exp_q;
   assign bus.out_inexact = out_inexact_q;
   assign bus.out_sign    = out_sign_q;
   assign bus.stall_cnt   = stall_q;

endmodule

// File: doc/round_share_arb.md
# round_share_arb

Shares one IEEE-754 single-precision rounding unit between two multiplier lanes. Each lane hands over its normalized pre-round mantissa, guard/sticky bits, sign, exponent and rounding mode through a valid/ready handshake. The block arbitrates between the lanes (round-robin, or lane 0 fixed priority), drives the shared rounding datapath and registers the rounded result with a lane tag. It sits between the two mantissa-multiply/normalize stages and the packing/exception stage.

## Interface
- PRIO_FIXED, 0, 0 = round-robin; 1 = lane 0 always wins contention
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in0_valid / in1_valid  in  1  lane request
- in0_ready / in1_ready  out  1  lane accepted this cycle
- inK_mantissa  in  24  pre-round mantissa (K = 0, 1)
- inK_guard, inK_sticky, inK_sign  in  1 each  rounding bits and sign
- inK_exp  in  10  pre-round exponent
- inK_round  in  3  mode: 000 near-even, 001 zero, 010 +inf, 011 −inf, 100 near-up, 101 away-zero
- out_valid  out  1  result register holds data
- out_ready  in  1  downstream accepts
- out_lane  out  1  lane that produced the result
- out_result  out  25  rounded mantissa
- out_exp  out  10  post-round exponent
- out_inexact, out_sign  out  1 each  guard|sticky; sign passthrough
- stall_cnt  out  16  saturating count of cycles with at least one lane stalled

## Operation
- out_free = !out_valid || out_ready.
- Grant:
  - Only one lane valid: that lane.
  - Both valid, PRIO_FIXED=1: lane 0.
  - Both valid, PRIO_FIXED=0: the lane other than last_grant.
- inK_ready = out_free && grant==K && inK_valid.
- inK_ready may depend combinationally on the other lane's valid. A lane must hold all fields stable while valid && !ready.
- Accept: the granted lane's fields are muxed into the rounding datapath (round_mult semantics).
  - Codes 110/111 round as near-even.
  - Result, exponent, inexact, sign and lane are captured in the output register.
  - last_grant is updated to the accepted lane.
- Mantissa carry-out: result = {1, sum[24:1]}, exp + 1.
- Exponent is 10-bit modulo. No saturation or overflow flag in this block.
- Output register:
  - Loaded on accept.
  - out_valid cleared when out_ready && out_valid && no accept.
  - Held stable while out_valid && !out_ready.
- Simultaneous drain and accept: the register is reloaded with no bubble, and out_valid stays 1.
- stall_cnt increments (saturating at 0xFFFF) in any cycle where (in0_valid && !in0_ready) || (in1_valid && !in1_ready).

## Timing
- Reset values:
  - out_valid = 0, out_lane = 0, out_result = 0, out_exp = 0, out_inexact = 0, out_sign = 0, stall_cnt = 0.
  - last_grant = 1, so lane 0 wins first contention.
- Latency: input accepted at edge N → out_valid = 1 with its data after edge N, visible in cycle N+1.
- Throughput: 1 result/cycle while out_ready = 1. Under contention each lane gets 1/2 (round-robin).
- Reset mid-operation: the pending result is discarded and all state returns to reset values asynchronously. Ready outputs go low while rst_n = 0.
- No combinational path from out_ready to out_* data. Only inK_ready is combinational on out_ready.

## Structure
- Shared package fp_mult_pkg:
  - round_set enum and 3-bit mode constants.
  - Widths: MANT_W = 24, EXP_W = 10, RES_W = 25.
  - A packed struct for the lane request bundle.
- One sub-module: the existing rounding unit round_mult, instantiated once and fed by the grant mux.
- Arbiter, output register and counter live in this module.

## Test plan
- Lane 0 only, mantissa 0x800001, g=1, s=0, mode 000, exp 0x080 → next cycle:
  - out_result = 0x0800002, out_exp = 0x080, out_inexact = 1, out_lane = 0.
- Lane 1 only, mantissa 0xFFFFFF, g=1, s=0, mode 000, exp 0x080 → carry-out:
  - out_result = 0x1800000, out_exp = 0x081, out_lane = 1.
- Both lanes valid for 4 cycles, out_ready = 1, PRIO_FIXED=0 → out_lane sequence 0,1,0,1; stall_cnt = 4 after the first 4 cycles. Rerun with PRIO_FIXED=1 → lane 0 on every accept, lane 1 starved.
- out_valid = 1, out_ready = 0 for 3 cycles with lane 0 valid → in0_ready = 0, output fields unchanged, stall_cnt += 3. Raise out_ready → drain and accept in the same cycle, no bubble.
- Mode 101, g=0, s=0, mantissa 0x123456 → out_result = 0x0123456, inexact = 0. Mode 010, sign = 1, g = 1 → no increment.
- Assert rst_n low while out_valid = 1 and both lanes are valid → all outputs immediately reset. After release, the first contention is granted to lane 0.
